decode_operand_unit: RTL and testbench

DECODE_OPERAND_UNIT -- requirements
Module: decode_operand_unit

---
 rtl/decode_operand_unit_pkg.sv | 16 +
 rtl/decode_operand_unit_regfile_array.sv | 69 ++++++
 rtl/decode_operand_unit.sv | 83 ++++++++
 tb/tb_decode_operand_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_operand_unit_pkg.sv
// -----------------------------------------------------------------------------
// decode_operand_unit_pkg
// Shared constants for the decode/operand unit: default widths, register-file
// geometry, special register indices and immediate field widths.
// -----------------------------------------------------------------------------
package decode_operand_unit_pkg;

   localparam int unsigned DATA_W      = 16;  // register / immediate / compare width
   localparam int unsigned ADDR_W      = 3;   // register address width
   localparam int unsigned NUM_REGS    = 8;   // register file depth
   localparam int unsigned REG_ZERO    = 0;   // hard-wired zero register
   localparam int unsigned REG_RA      = 7;   // return-address register
   localparam int unsigned IMM_SHORT_W = 5;   // short immediate field imm_in[4:0]
   localparam int unsigned IMM_LONG_W  = 8;   // long immediate field imm_in[7:0]

endpackage

// File: rtl/decode_operand_unit_regfile_array.sv
// -----------------------------------------------------------------------------
// regfile_array
// 8-entry register file with two combinational read ports plus a dedicated
// read of register 7. Register 0 is never written and therefore always reads 0.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (clears all entries)
//   ra, rb           read addresses, ports A and B
//   rw, we, wdata    write address, write enable, write data
//   rdata_a/_b       read data, ports A and B
//   rdata_ra         continuous copy of register 7
//
// Optional macro REGFILE_BYPASS_EN: when defined, a read whose address matches
// an active write (we=1, rw!=0) returns wdata in the same cycle.
// -----------------------------------------------------------------------------
module regfile_array
   import decode_operand_unit_pkg::*;
#(
   parameter int unsigned DATA_W = decode_operand_unit_pkg::DATA_W,
   parameter int unsigned ADDR_W = decode_operand_unit_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   input  logic [ADDR_W-1:0] rw,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic [DATA_W-1:0] rdata_ra
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              wr_en;

   // Writes to register 0 are dropped here, so its entry stays at its reset 0.
   assign wr_en = we && (rw != ADDR_W'(REG_ZERO));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[rw] <= wdata;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic wr_hit;

   // Gated by rst_n so reads stay 0 while reset is held.
   assign wr_hit = rst_n && wr_en;

   always_comb begin
      rdata_a  = (wr_hit && (ra == rw)) ? wdata : regs_q[ra];
      rdata_b  = (wr_hit && (rb == rw)) ? wdata : regs_q[rb];
      rdata_ra = (wr_hit && (rw == ADDR_W'(REG_RA))) ? wdata : regs_q[REG_RA];
   end
`else
   always_comb begin
      rdata_a  = regs_q[ra];
      rdata_b  = regs_q[rb];
      rdata_ra = regs_q[REG_RA];
   end
`endif

endmodule

// File: rtl/decode_operand_unit.sv
// -----------------------------------------------------------------------------
// decode_operand_unit
// Operand stage: register file (via regfile_array), immediate extender and
// signed comparator. The extender and comparator are purely combinational.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   RA, RB, RW              read A / read B / write addresses
//   enableWrite, BusW       write enable and write data
//   BusA, BusB, R7          read data A / B, continuous copy of register 7
//   imm_in, ExtOp, ExtPlace raw immediate, 1=sign/0=zero extend,
//                           field select 0=imm_in[4:0] / 1=imm_in[7:0]
//   imm_out                 extended immediate
//   cmp_a, cmp_b            signed compare operands
//   gt, lt, eq              compare results (exactly one is set)
//
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read bypass in the
// register file (see regfile_array).
// -----------------------------------------------------------------------------
module decode_operand_unit
   import decode_operand_unit_pkg::*;
#(
   parameter int unsigned DATA_W = decode_operand_unit_pkg::DATA_W,
   parameter int unsigned ADDR_W = decode_operand_unit_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   input  logic [ADDR_W-1:0] RW,
   input  logic              enableWrite,
   input  logic [DATA_W-1:0] BusW,
   output logic [DATA_W-1:0] BusA,
   output logic [DATA_W-1:0] BusB,
   output logic [DATA_W-1:0] R7,
   input  logic [7:0]        imm_in,
   input  logic              ExtOp,
   input  logic              ExtPlace,
   output logic [DATA_W-1:0] imm_out,
   input  logic [DATA_W-1:0] cmp_a,
   input  logic [DATA_W-1:0] cmp_b,
   output logic              gt,
   output logic              lt,
   output logic              eq
);

   regfile_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra       (RA),
      .rb       (RB),
      .rw       (RW),
      .we       (enableWrite),
      .wdata    (BusW),
      .rdata_a  (BusA),
      .rdata_b  (BusB),
      .rdata_ra (R7)
   );

   // Immediate extender: fill bit is the field MSB for sign extension, else 0.
   logic ext_fill;

   always_comb begin
      if (ExtPlace) begin
         ext_fill = ExtOp & imm_in[IMM_LONG_W-1];
         imm_out  = {{(DATA_W - IMM_LONG_W){ext_fill}}, imm_in[IMM_LONG_W-1:0]};
      end else begin
         ext_fill = ExtOp & imm_in[IMM_SHORT_W-1];
         imm_out  = {{(DATA_W - IMM_SHORT_W){ext_fill}}, imm_in[IMM_SHORT_W-1:0]};
      end
   end

   // Signed comparator; the three relations are mutually exclusive by construction.
   always_comb begin
      gt = $signed(cmp_a) > $signed(cmp_b);
      lt = $signed(cmp_a) < $signed(cmp_b);
      eq = (cmp_a == cmp_b);
   end

endmodule

// File: tb/tb_decode_operand_unit.sv
module tb_decode_operand_unit;

   logic        clk;
   logic        rst_n;
   logic [2:0]  RA, RB, RW;
   logic        enableWrite;
   logic [15:0] BusW, BusA, BusB, R7;
   logic [7:0]  imm_in;
   logic        ExtOp, ExtPlace;
   logic [15:0] imm_out;
   logic [15:0] cmp_a, cmp_b;
   logic        gt, lt, eq;

   int n_vec;
   int n_fail;
   bit checking;

   // Architectural register state as plain integers
   int mdl [8];

   decode_operand_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .RA          (RA),
      .RB          (RB),
      .RW          (RW),
      .enableWrite (enableWrite),
      .BusW        (BusW),
      .BusA        (BusA),
      .BusB        (BusB),
      .R7          (R7),
      .imm_in      (imm_in),
      .ExtOp       (ExtOp),
      .ExtPlace    (ExtPlace),
      .imm_out     (imm_out),
      .cmp_a       (cmp_a),
      .cmp_b       (cmp_b),
      .gt          (gt),
      .lt          (lt),
      .eq          (eq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 8; i++) mdl[i] = 0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mdl[i] <= 0;
      end else if (enableWrite && RW != 3'd0) begin
         mdl[RW] <= int'(BusW);
      end
   end

   function automatic logic [15:0] exp_read(input logic [2:0] a);
      if (!rst_n) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
      if (enableWrite && RW != 3'd0 && a == RW) return BusW;
`endif
      return 16'(mdl[a]);
   endfunction

   function automatic logic [15:0] exp_imm(input logic [7:0] imm, input logic place,
                                          input logic op);
      int f, w;
      w = place ? 8 : 5;
      f = place ? int'(imm) : int'(imm) % 32;
      if (op && f >= (1 << (w - 1))) f = f - (1 << w);
      return 16'(f);
   endfunction

   // Returns {gt, lt, eq}
   function automatic logic [2:0] exp_cmp(input logic [15:0] a, input logic [15:0] b);
      int sa, sb;
      sa = (int'(a) >= 32768) ? int'(a) - 65536 : int'(a);
      sb = (int'(b) >= 32768) ? int'(b) - 65536 : int'(b);
      if (sa > sb) return 3'b100;
      if (sa < sb) return 3'b010;
      return 3'b001;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("model BusA", BusA, exp_read(RA));
         chk("model BusB", BusB, exp_read(RB));
         chk("model R7", R7, exp_read(3'd7));
         chk("model imm_out", imm_out, exp_imm(imm_in, ExtPlace, ExtOp));
         chk("model gt/lt/eq", {13'd0, gt, lt, eq}, {13'd0, exp_cmp(cmp_a, cmp_b)});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [2:0] r, input logic [15:0] d);
      RW = r;
      BusW = d;
      enableWrite = 1'b1;
      cyc();
      enableWrite = 1'b0;
   endtask

   logic [15:0] cmp_tab_a [6];
   logic [15:0] cmp_tab_b [6];
   logic [7:0]  imm_tab   [5];

   initial begin
      n_vec = 0;
      n_fail = 0;
      checking = 0;
      rst_n = 1'b0;
      RA = '0; RB = '0; RW = '0; enableWrite = 1'b0; BusW = '0;
      imm_in = '0; ExtOp = 1'b0; ExtPlace = 1'b0; cmp_a = '0; cmp_b = '0;

      cmp_tab_a = '{16'h0005, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFE};
      cmp_tab_b = '{16'h0005, 16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF};
      imm_tab   = '{8'h00, 8'h10, 8'h0F, 8'h80, 8'h7F};

      cyc();
      checking = 1;
      cyc();
      rst_n = 1'b1;

      // Reset state on every address
      for (int a = 0; a < 8; a++) begin
         RA = 3'(a);
         RB = 3'(7 - a);
         #1;
         chk("reset BusA", BusA, 16'h0000);
         chk("reset BusB", BusB, 16'h0000);
         chk("reset R7", R7, 16'h0000);
         cyc();
      end

      // Write R3, read next cycle; R0 writes discarded
      write_reg(3'd3, 16'h1234);
      RA = 3'd3;
      #1 chk("R3 readback", BusA, 16'h1234);
      write_reg(3'd0, 16'hFFFF);
      RA = 3'd0;
      #1 chk("R0 stays zero", BusA, 16'h0000);

      // R7 write with same-cycle read
      RW = 3'd7; BusW = 16'hBEEF; enableWrite = 1'b1; RA = 3'd7;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("R7 same-cycle", R7, 16'hBEEF);
      chk("BusA same-cycle", BusA, 16'hBEEF);
`else
      chk("R7 same-cycle", R7, 16'h0000);
      chk("BusA same-cycle", BusA, 16'h0000);
`endif
      cyc();
      enableWrite = 1'b0;
      #1 chk("R7 after write", R7, 16'hBEEF);

      // Fill registers 1..6, then sweep reads
      for (int r = 1; r < 7; r++) write_reg(3'(r), 16'(r * 16'h1111 ^ 16'h0F0F));
      for (int a = 0; a < 8; a++) begin
         RA = 3'(a);
         RB = 3'((a + 3) % 8);
         cyc();
      end
      RA = 3'd5;
      #1 chk("R5 literal", BusA, 16'h5A5A);

      // Immediate extender
      imm_in = 8'h95;
      ExtPlace = 1'b1; ExtOp = 1'b1; #1 chk("imm 8b sext", imm_out, 16'hFF95);
      ExtPlace = 1'b1; ExtOp = 1'b0; #1 chk("imm 8b zext", imm_out, 16'h0095);
      ExtPlace = 1'b0; ExtOp = 1'b1; #1 chk("imm 5b sext", imm_out, 16'hFFF5);
      ExtPlace = 1'b0; ExtOp = 1'b0; #1 chk("imm 5b zext", imm_out, 16'h0015);
      for (int i = 0; i < 5; i++) begin
         for (int m = 0; m < 4; m++) begin
            imm_in = imm_tab[i];
            ExtPlace = m[1];
            ExtOp = m[0];
            cyc();
         end
      end

      // Comparator
      cmp_a = 16'h0005; cmp_b = 16'h0005; #1 chk("cmp 5,5", {13'd0, gt, lt, eq}, 16'h0001);
      cmp_a = 16'hFFFF; cmp_b = 16'h0001; #1 chk("cmp -1,1", {13'd0, gt, lt, eq}, 16'h0002);
      cmp_a = 16'h7FFF; cmp_b = 16'h8000; #1 chk("cmp max,min", {13'd0, gt, lt, eq}, 16'h0004);
      cmp_a = 16'h8000; cmp_b = 16'h7FFF; #1 chk("cmp min,max", {13'd0, gt, lt, eq}, 16'h0002);
      for (int i = 0; i < 6; i++) begin
         cmp_a = cmp_tab_a[i];
         cmp_b = cmp_tab_b[i];
         cyc();
      end

      // Asynchronous reset mid-cycle
      write_reg(3'd3, 16'h1234);
      RA = 3'd3;
      #1 chk("R3 before reset", BusA, 16'h1234);
      rst_n = 1'b0;
      #1 chk("R3 async clear", BusA, 16'h0000);
      chk("R7 async clear", R7, 16'h0000);

      // Writes ignored under reset; first write after release lands
      RW = 3'd5; BusW = 16'hAAAA; enableWrite = 1'b1; RA = 3'd5;
      cyc();
      #1 chk("write under reset", BusA, 16'h0000);
      rst_n = 1'b1;
      enableWrite = 1'b0;
      #1 chk("after release", BusA, 16'h0000);
      write_reg(3'd5, 16'hC3C3);
      #1 chk("first write after reset", BusA, 16'hC3C3);
      cyc();
      cyc();

      checking = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
